// File: rtl/bridge_stream_reader.sv
// Bridge (Avalon master) burst reader feeding a valid/ready stream via a FIFO.
// Optional BSR_LOOP_EN adds loop_en to replay the same window repeatedly.
module bridge_stream_reader #(
  parameter int DATA_W     = 128,
  parameter int ADDR_W     = 26,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_address,
  input  logic [LEN_W-1:0]              num_words,
  input  logic                          abort,
`ifdef BSR_LOOP_EN
  input  logic                          loop_en,
`endif
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             interface_address,
  output logic [DATA_W/8-1:0]           interface_byte_enable,
  output logic                          interface_read,
  input  logic                          interface_acknowledge,
  input  logic [DATA_W-1:0]             interface_read_data,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int BE_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remaining;
  logic              rd_q;
  logic              abort_pend;
  logic              done_q;

  logic [DATA_W-1:0] mem      [FIFO_DEPTH];
  logic              last_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level;

  logic ack_hit;
  logic drop;
  logic push;
  logic pop;
  logic final_word;
  logic last_pop;
  logic loop_go;

`ifdef BSR_LOOP_EN
  assign loop_go = loop_en;
`else
  assign loop_go = 1'b0;
`endif

  assign ack_hit    = (state == S_WAIT) && rd_q
                      && interface_acknowledge;
  assign drop       = abort || abort_pend;
  assign push       = ack_hit && !drop;
  assign m_valid    = (level != '0) && (state != S_FLUSH);
  assign pop        = m_valid && m_ready;
  assign final_word = (remaining == LEN_W'(1));
  assign last_pop   = pop && (level == LW'(1));

  assign busy                  = (state != S_IDLE);
  assign done                  = done_q;
  assign interface_read        = rd_q;
  assign interface_address     = addr_q;
  assign interface_byte_enable = {BE_W{rd_q}};
  assign m_data                = mem[rd_ptr];
  assign m_last                = m_valid && last_mem[rd_ptr];
  assign fifo_level            = level;

  // Transfer sequencing: one outstanding read, abort drains through FLUSH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      remaining  <= '0;
      rd_q       <= 1'b0;
      abort_pend <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start && !abort) begin
            if (num_words != '0) begin
              base_q    <= base_address;
              len_q     <= num_words;
              addr_q    <= base_address;
              remaining <= num_words;
              state     <= S_REQ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (level < LW'(FIFO_DEPTH)) begin
            rd_q  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack_hit) begin
            rd_q <= 1'b0;
            if (drop) begin
              state <= S_FLUSH;
            end else if (final_word) begin
              if (loop_go) begin
                addr_q    <= base_q;
                remaining <= len_q;
                state     <= S_REQ;
              end else begin
                addr_q    <= addr_q + ADDR_W'(BE_W);
                remaining <= remaining - LEN_W'(1);
                state     <= S_DRAIN;
              end
            end else begin
              addr_q    <= addr_q + ADDR_W'(BE_W);
              remaining <= remaining - LEN_W'(1);
              state     <= S_REQ;
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (last_pop) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_FLUSH: begin
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; FLUSH clears everything in one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (state == S_FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage, tagged with the end-of-pass marker
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= interface_read_data;
      last_mem[wr_ptr] <= final_word;
    end
  end

endmodule

// File: tb/tb_bridge_stream_reader.sv
// Bench for bridge_stream_reader: bus responder, random sink, reference model.
// Directed steps with randomized data, delays and sink backpressure.
module tb_bridge_stream_reader;

  localparam int DW    = 128;
  localparam int AW    = 26;
  localparam int LNW   = 16;
  localparam int DEPTH = 4;
  localparam int BE    = DW / 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [AW-1:0]     base_address;
  logic [LNW-1:0]    num_words;
  logic              abort;
`ifdef BSR_LOOP_EN
  logic              loop_en;
`endif
  logic              busy;
  logic              done;
  logic [AW-1:0]     interface_address;
  logic [BE-1:0]     interface_byte_enable;
  logic              interface_read;
  logic              interface_acknowledge;
  logic [DW-1:0]     interface_read_data;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [$clog2(DEPTH):0] fifo_level;

  bridge_stream_reader #(
    .DATA_W(DW), .ADDR_W(AW), .LEN_W(LNW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_address(base_address),
    .num_words(num_words),
    .abort(abort),
`ifdef BSR_LOOP_EN
    .loop_en(loop_en),
`endif
    .busy(busy),
    .done(done),
    .interface_address(interface_address),
    .interface_byte_enable(interface_byte_enable),
    .interface_read(interface_read),
    .interface_acknowledge(interface_acknowledge),
    .interface_read_data(interface_read_data),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last(m_last),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] salt = 32'h0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a,
                                             input logic [31:0] s);
    logic [31:0] x;
    x = 32'(a) ^ s;
    return {x * 32'h9E37_79B1, ~x, x + 32'h1357_9BDF,
            {x[15:0], x[31:16]}};
  endfunction

  // Bus responder: acknowledges each read after a delay with model data
  int ack_delay = 2;
  bit ack_rand = 1'b0;
  int wcnt = 0;
  int cur_delay = 1;
  logic [AW-1:0] rd_log[$];

  initial begin
    interface_acknowledge = 1'b0;
    interface_read_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        interface_acknowledge = 1'b0;
        wcnt = 0;
      end else if (interface_acknowledge) begin
        interface_acknowledge = 1'b0;
      end else if (interface_read) begin
        if (wcnt == 0)
          cur_delay = ack_rand ? int'($urandom_range(1, 4)) : ack_delay;
        wcnt++;
        if (wcnt >= cur_delay) begin
          interface_acknowledge = 1'b1;
          interface_read_data = mem_word(interface_address, salt);
          rd_log.push_back(interface_address);
          wcnt = 0;
        end
      end
    end
  end

  // Sink: drives m_ready by mode and records every popped beat
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;
  beat_t pops[$];
  int ready_mode = 1;
  int last_pop_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (reset_n && m_valid && m_ready) begin
        pops.push_back('{m_data, m_last});
        last_pop_cyc = cyc;
      end
      if (reset_n && done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input int n);
    rd_log.delete();
    pops.delete();
    done_cnt = 0;
    salt = $urandom;
    base_address = b;
    num_words = LNW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, DW'(k < budget), DW'(1));
    tick(2);
  endtask

  task automatic wait_cond_level(input int lvl, input bit need_rd,
                                 input string tag);
    int k;
    k = 0;
    while (!(int'(fifo_level) == lvl && (!need_rd || interface_read))
           && k < 400) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, DW'(k < 400), DW'(1));
  endtask

  // Reference: word i of pass p reads base + (i mod n)*BE, wrapping
  task automatic finish_xfer(input logic [AW-1:0] b, input int n,
                             input int passes, input string tag);
    int total;
    logic [AW-1:0] a;
    total = n * passes;
    check({tag, "_nreads"}, DW'(rd_log.size()), DW'(total));
    check({tag, "_npops"}, DW'(pops.size()), DW'(total));
    for (int i = 0; i < total; i++) begin
      a = AW'(32'(b) + 32'((i % n) * BE));
      if (i < rd_log.size())
        check($sformatf("%s_addr%0d", tag, i), DW'(rd_log[i]), DW'(a));
      if (i < pops.size()) begin
        check($sformatf("%s_data%0d", tag, i), pops[i].d, mem_word(a, salt));
        check($sformatf("%s_last%0d", tag, i), DW'(pops[i].l),
              DW'((i % n) == n - 1));
      end
    end
    check({tag, "_done_cnt"}, DW'(done_cnt), DW'(1));
    check({tag, "_done_lat"}, DW'(done_cyc), DW'(last_pop_cyc + 1));
  endtask

  initial begin
    logic [AW-1:0] rb;
    int rn;
    int k;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base_address = '0;
    num_words = '0;
`ifdef BSR_LOOP_EN
    loop_en = 1'b0;
`endif
    tick(3);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_read", DW'(interface_read), DW'(0));
    check("rst_addr", DW'(interface_address), DW'(0));
    check("rst_be", DW'(interface_byte_enable), DW'(0));
    check("rst_valid", DW'(m_valid), DW'(0));
    check("rst_last", DW'(m_last), DW'(0));
    check("rst_level", DW'(fifo_level), DW'(0));
    reset_n = 1'b1;
    tick(2);

    // Basic 4-word read
    ready_mode = 1;
    ack_rand = 1'b0;
    ack_delay = 2;
    start_xfer(AW'(32'h100), 4);
    check("t1_busy", DW'(busy), DW'(1));
    tick(3);
    check("t1_be", DW'(interface_byte_enable),
          interface_read ? DW'({BE{1'b1}}) : DW'(0));
    wait_idle(300, "t1");
    finish_xfer(AW'(32'h100), 4, 1, "t1");

    // Backpressure: FIFO fills and requests stop
    ready_mode = 0;
    start_xfer(AW'(32'h2000), 10);
    wait_cond_level(DEPTH, 1'b0, "t2_fill");
    tick(6);
    check("t2_nreads", DW'(rd_log.size()), DW'(DEPTH));
    check("t2_read_low", DW'(interface_read), DW'(0));
    check("t2_level", DW'(fifo_level), DW'(DEPTH));
    check("t2_valid", DW'(m_valid), DW'(1));
    ready_mode = 1;
    wait_idle(500, "t2");
    finish_xfer(AW'(32'h2000), 10, 1, "t2");

    // Abort while a read is outstanding
    ready_mode = 0;
    ack_delay = 3;
    start_xfer(AW'(32'h400), 5);
    wait_cond_level(2, 1'b1, "t3_sync");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_read_held", DW'(interface_read), DW'(1));
    wait_idle(100, "t3");
    check("t3_level", DW'(fifo_level), DW'(0));
    check("t3_valid", DW'(m_valid), DW'(0));
    check("t3_read", DW'(interface_read), DW'(0));
    check("t3_no_done", DW'(done_cnt), DW'(0));
    check("t3_no_pops", DW'(pops.size()), DW'(0));
    check("t3_nreads", DW'(rd_log.size()), DW'(3));

    // Address wrap with random backpressure and ack delays
    ready_mode = 2;
    ack_rand = 1'b1;
    rb = AW'(32'h0400_0000 - 32'h20);
    start_xfer(rb, 3);
    wait_idle(300, "t4");
    finish_xfer(rb, 3, 1, "t4");

    // Zero-length request
    start_xfer(AW'(32'h500), 0);
    check("t4z_busy", DW'(busy), DW'(0));
    tick(3);
    check("t4z_done", DW'(done_cnt), DW'(1));
    check("t4z_reads", DW'(rd_log.size()), DW'(0));
    check("t4z_busy2", DW'(busy), DW'(0));

    // Asynchronous reset mid-transfer
    ready_mode = 0;
    ack_rand = 1'b0;
    ack_delay = 1;
    start_xfer(AW'(32'h800), 8);
    wait_cond_level(3, 1'b0, "t5_sync");
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_busy", DW'(busy), DW'(0));
    check("t5_done", DW'(done), DW'(0));
    check("t5_read", DW'(interface_read), DW'(0));
    check("t5_addr", DW'(interface_address), DW'(0));
    check("t5_be", DW'(interface_byte_enable), DW'(0));
    check("t5_valid", DW'(m_valid), DW'(0));
    check("t5_last", DW'(m_last), DW'(0));
    check("t5_level", DW'(fifo_level), DW'(0));
    tick(2);
    reset_n = 1'b1;
    tick(2);
    ready_mode = 1;
    ack_delay = 2;
    start_xfer(AW'(32'h100), 4);
    wait_idle(300, "t5b");
    finish_xfer(AW'(32'h100), 4, 1, "t5b");

    // Randomized transfers
    ready_mode = 2;
    ack_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rb = AW'($urandom) & ~AW'(BE - 1);
      rn = int'($urandom_range(1, 12));
      start_xfer(rb, rn);
      wait_idle(1000, $sformatf("rnd%0d", r));
      finish_xfer(rb, rn, 1, $sformatf("rnd%0d", r));
    end

`ifdef BSR_LOOP_EN
    // Looping: three passes over a 2-word window
    ready_mode = 1;
    ack_rand = 1'b0;
    ack_delay = 2;
    loop_en = 1'b1;
    start_xfer(AW'(32'h600), 2);
    k = 0;
    while (rd_log.size() < 4 && k < 300) begin
      tick();
      k++;
    end
    check("t6_sync_timeout", DW'(k < 300), DW'(1));
    loop_en = 1'b0;
    wait_idle(300, "t6");
    finish_xfer(AW'(32'h600), 2, 3, "t6");
`else
    k = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
